deserializer: RTL and testbench
===============================

# deserializer

Receive-side counterpart of the word serializer in the FFT datapath. Collects a stream of WORD_SIZE-bit words, first word in the least-significant slot, into one FRAME_SIZE-bit frame. Presents the frame with a valid/ready handshake to the downstream FFT input stage. Optionally checks frame alignment against the sender's end-of-frame pulse.

## Interface
- WORD_SIZE, 16, width of each incoming word
- FRAME_SIZE, 256, width of assembled frame; integer multiple of WORD_SIZE, ratio NUM_WORDS ≥ 2
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- input_valid  input  1  input_data carries a word this cycle
- input_data  input  WORD_SIZE  incoming word
- input_last  input  1  sender's end-of-frame pulse (driven by serialization_done); used only with DESERIALIZER_LAST_CHECK_EN
- output_ready  input  1  consumer accepts frame
- output_valid  output  1  output_data holds a complete frame
- output_data  output  FRAME_SIZE  assembled frame
- deserialization_done  output  1  one-cycle pulse, first cycle of each new output_valid
- overrun  output  1  one-cycle pulse, word dropped because frame still pending
- frame_error  output  1  one-cycle pulse, misaligned frame discarded (always 0 without macro)

## Operation
- Reset: all outputs 0, word_count 0, buffer 0, state COLLECT.
- COLLECT: on input_valid, write input_data to buffer[word_count*WORD_SIZE +: WORD_SIZE] and increment word_count.
  - Word at count NUM_WORDS-1 completes the frame: copy the buffer to output_data, set output_valid, pulse deserialization_done, reset word_count to 0, go to HOLD.
- HOLD: output_valid and output_data stay stable until output_ready=1 is sampled; then output_valid drops and the state returns to COLLECT.
- HOLD with input_valid:
  - If output_ready=1 in the same cycle, the word is accepted as word 0 of the next frame. Nothing is lost.
  - If output_ready=0, the word is dropped and overrun pulses. word_count stays 0.
- word_count width is $clog2(NUM_WORDS). Wrap to 0 is explicit on completion, never by overflow.
- Mid-frame reset discards partial data. Deassertion restarts at word 0.

## Timing
- Latency: frame visible one cycle after the clock edge that samples the last word.
- output_valid rises in that same cycle; deserialization_done is high for exactly that one cycle.
- Back-to-back frames are sustained when the consumer asserts output_ready at the first cycle of output_valid.
- The frame is released one cycle after the handshake cycle (output_valid & output_ready).
- overrun and frame_error are registered and assert one cycle after the offending input.

## Configuration
- DESERIALIZER_LAST_CHECK_EN defined:
  - input_last with input_valid at word_count ≠ NUM_WORDS-1: frame_error pulses, the partial frame is discarded and word_count returns to 0. The current word is not stored.
  - Word at count NUM_WORDS-1 without input_last: frame_error pulses, the frame is discarded and not presented.
- Not defined: input_last is ignored, frame boundaries come from the count alone, and frame_error is tied to 0.

## Structure
- Shared package deser_pkg holds:
  - state enum (COLLECT, HOLD)
  - function computing NUM_WORDS and the count width from the two parameters
- Single module; no sub-module is warranted. Buffer, counter and output register are all local.

## Test plan
Configuration: WORD_SIZE=16, FRAME_SIZE=256, NUM_WORDS=16.
- Reset check: assert reset_n=0 mid-frame after 5 words, then send 16 words. Required: all outputs 0 during reset; the frame holds only the new 16 words.
- Words 0x0000..0x000F back-to-back, output_ready=1. Required: output_data=0x000F_000E_..._0001_0000 one cycle after the 16th word, with deserialization_done pulsed once.
- Frame pending with output_ready=0 and 3 more words sent. Required: three overrun pulses; output_data unchanged; after ready, the next frame starts from word 0.
- Ready and word 0xAAAA coincide in HOLD. Required: no overrun; the next frame's bits [15:0] are 0xAAAA.
- With macro, input_last on the 10th word. Required: frame_error pulse and no output_valid. A following 16-word frame with input_last on word 16 is delivered intact.
- Without macro, input_last toggled randomly during 16 words. Required: normal frame and frame_error never asserted.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared types and size helpers for the word-to-frame deserializer.
// Used by rtl/deserializer.sv; see that file for the DESERIALIZER_LAST_CHECK_EN option.
package deser_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  function automatic int num_words(input int word_size, input int frame_size);
    return frame_size / word_size;
  endfunction

  // A frame always has at least two words, so the counter is never narrower than 1 bit.
  function automatic int count_width(input int word_size, input int frame_size);
    int n;
    n = frame_size / word_size;
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/deserializer_if.sv
// Word-in / frame-out handshake bundle of the deserializer.
// master = word source and frame consumer side, slave = deserializer side.
interface deserializer_if #(
  parameter int WORD_SIZE  = 16,
  parameter int FRAME_SIZE = 256
);
  logic                  input_valid;
  logic [WORD_SIZE-1:0]  input_data;
  logic                  input_last;
  logic                  output_ready;
  logic                  output_valid;
  logic [FRAME_SIZE-1:0] output_data;
  logic                  deserialization_done;
  logic                  overrun;
  logic                  frame_error;

  modport master (
    output input_valid, input_data, input_last, output_ready,
    input  output_valid, output_data, deserialization_done, overrun, frame_error
  );

  modport slave (
    input  input_valid, input_data, input_last, output_ready,
    output output_valid, output_data, deserialization_done, overrun, frame_error
  );
endinterface

// File: rtl/deserializer.sv
// Collects WORD_SIZE-bit words (first word in the LSB slot) into one FRAME_SIZE-bit frame.
// Define DESERIALIZER_LAST_CHECK_EN to check frame alignment against input_last.
module deserializer
  import deser_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int FRAME_SIZE = 256
) (
  input  logic           clk,
  input  logic           reset_n,
  deserializer_if.slave  bus
);

  localparam int             NUM_WORDS  = num_words(WORD_SIZE, FRAME_SIZE);
  localparam int             CW         = count_width(WORD_SIZE, FRAME_SIZE);
  localparam logic [CW-1:0]  LAST_COUNT = CW'(NUM_WORDS - 1);

  state_t                state_r, state_n;
  logic [CW-1:0]         count_r, count_n;
  logic [FRAME_SIZE-1:0] buffer_r, buffer_n;
  logic [FRAME_SIZE-1:0] data_r, data_n;
  logic                  valid_r, valid_n;
  logic                  done_r, done_n;
  logic                  overrun_r, overrun_n;
  logic                  ferr_r, ferr_n;
  logic                  accept_s;
  logic                  last_slot_s;
  logic                  align_ok_s;
  logic [FRAME_SIZE-1:0] word_buffer_s;

  // Buffer contents with the incoming word placed in the current slot.
  always_comb begin
    word_buffer_s = buffer_r;
    word_buffer_s[int'(count_r) * WORD_SIZE +: WORD_SIZE] = bus.input_data;
  end

  assign last_slot_s = (count_r == LAST_COUNT);

`ifdef DESERIALIZER_LAST_CHECK_EN
  assign align_ok_s = (bus.input_last == last_slot_s);
`else
  assign align_ok_s = 1'b1;
`endif

  // Next-state, buffer and output-register logic.
  always_comb begin
    state_n   = state_r;
    count_n   = count_r;
    buffer_n  = buffer_r;
    data_n    = data_r;
    valid_n   = valid_r;
    done_n    = 1'b0;
    overrun_n = 1'b0;
    ferr_n    = 1'b0;
    accept_s  = 1'b0;

    case (state_r)
      COLLECT: accept_s = bus.input_valid;
      HOLD: begin
        if (bus.output_ready) begin
          valid_n  = 1'b0;
          state_n  = COLLECT;
          accept_s = bus.input_valid;
        end else begin
          overrun_n = bus.input_valid;
        end
      end
      default: begin
        state_n = COLLECT;
        valid_n = 1'b0;
        count_n = '0;
      end
    endcase

    // In HOLD the counter is 0, so a word accepted there can never complete a frame.
    if (accept_s) begin
      if (!align_ok_s) begin
        ferr_n  = 1'b1;
        count_n = '0;
      end else if (last_slot_s) begin
        data_n  = word_buffer_s;
        valid_n = 1'b1;
        done_n  = 1'b1;
        count_n = '0;
        state_n = HOLD;
      end else begin
        buffer_n = word_buffer_s;
        count_n  = count_r + CW'(1);
      end
    end else begin
      buffer_n = buffer_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= COLLECT;
      count_r   <= '0;
      buffer_r  <= '0;
      data_r    <= '0;
      valid_r   <= 1'b0;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      count_r   <= count_n;
      buffer_r  <= buffer_n;
      data_r    <= data_n;
      valid_r   <= valid_n;
      done_r    <= done_n;
      overrun_r <= overrun_n;
      ferr_r    <= ferr_n;
    end
  end

  assign bus.output_valid         = valid_r;
  assign bus.output_data          = data_r;
  assign bus.deserialization_done = done_r;
  assign bus.overrun              = overrun_r;
  assign bus.frame_error          = ferr_r;

endmodule

// File: tb/tb_deserializer.sv
// Randomized self-checking bench for deserializer against a queue-based frame model.
// Honours DESERIALIZER_LAST_CHECK_EN in the same way as the design.
module tb_deserializer;

  localparam int WS = 16;
  localparam int FS = 256;
  localparam int NW = FS / WS;
`ifdef DESERIALIZER_LAST_CHECK_EN
  localparam bit LAST_CHECK_EN = 1'b1;
`else
  localparam bit LAST_CHECK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  deserializer_if #(.WORD_SIZE(WS), .FRAME_SIZE(FS)) bus ();

  deserializer #(.WORD_SIZE(WS), .FRAME_SIZE(FS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [WS-1:0] partial_q[$];
  bit            have_frame = 1'b0;
  logic [FS-1:0] exp_frame = '0;
  bit            exp_done, exp_overrun, exp_ferr;
  int            done_seen = 0;
  int            overrun_seen = 0;
  int            ferr_seen = 0;
  int            valid_seen = 0;

  task automatic check_eq(input string tag, input logic [FS-1:0] actual, input logic [FS-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [FS-1:0] frame_of(input logic [WS-1:0] base);
    logic [FS-1:0] f;
    f = '0;
    for (int i = 0; i < NW; i++) f[i*WS +: WS] = base + WS'(i);
    return f;
  endfunction

  // Frame-level model: a pending frame plus a queue of words collected so far.
  task automatic model_step(input bit v, input logic [WS-1:0] d, input bit l, input bit r);
    bit pending;
    pending     = have_frame;
    exp_done    = 1'b0;
    exp_overrun = 1'b0;
    exp_ferr    = 1'b0;
    if (pending && r) have_frame = 1'b0;
    if (v && pending && !r) begin
      exp_overrun = 1'b1;
    end else if (v) begin
      if (LAST_CHECK_EN && (l != (partial_q.size() == NW - 1))) begin
        exp_ferr = 1'b1;
        partial_q.delete();
      end else begin
        partial_q.push_back(d);
        if (partial_q.size() == NW) begin
          for (int i = 0; i < NW; i++) exp_frame[i*WS +: WS] = partial_q[i];
          have_frame = 1'b1;
          exp_done   = 1'b1;
          partial_q.delete();
        end
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [WS-1:0] d, input bit l, input bit r);
    bus.input_valid  = v;
    bus.input_data   = d;
    bus.input_last   = l;
    bus.output_ready = r;
    @(posedge clk);
    model_step(v, d, l, r);
    #1;
    check_eq("output_valid", FS'(bus.output_valid), FS'(have_frame));
    if (have_frame) check_eq("output_data", bus.output_data, exp_frame);
    check_eq("deserialization_done", FS'(bus.deserialization_done), FS'(exp_done));
    check_eq("overrun", FS'(bus.overrun), FS'(exp_overrun));
    check_eq("frame_error", FS'(bus.frame_error), FS'(exp_ferr));
    if (bus.deserialization_done) done_seen++;
    if (bus.overrun) overrun_seen++;
    if (bus.frame_error) ferr_seen++;
    if (bus.output_valid) valid_seen++;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, FS'(bus.output_valid), '0);
    check_eq({tag, "_data"}, bus.output_data, '0);
    check_eq({tag, "_done"}, FS'(bus.deserialization_done), '0);
    check_eq({tag, "_overrun"}, FS'(bus.overrun), '0);
    check_eq({tag, "_frame_error"}, FS'(bus.frame_error), '0);
  endtask

  task automatic send_frame(input logic [WS-1:0] base, input bit r);
    for (int i = 0; i < NW; i++) cycle(1'b1, base + WS'(i), (i == NW - 1), r);
  endtask

  initial begin
    int d0, o0, f0, v0;
    bus.input_valid  = 1'b0;
    bus.input_data   = '0;
    bus.input_last   = 1'b0;
    bus.output_ready = 1'b0;
    #12;
    check_all_zero("reset_init");
    @(negedge clk);
    reset_n = 1'b1;

    // Mid-frame reset after five words, then a clean frame.
    for (int i = 0; i < 5; i++) cycle(1'b1, WS'($urandom), 1'b0, 1'b1);
    reset_n = 1'b0;
    #2;
    check_all_zero("reset_mid");
    partial_q.delete();
    have_frame = 1'b0;
    exp_frame  = '0;
    @(negedge clk);
    check_all_zero("reset_held");
    reset_n = 1'b1;
    send_frame(16'h1000, 1'b1);
    check_eq("post_reset_frame", bus.output_data, frame_of(16'h1000));

    // Incrementing words with the consumer always ready.
    d0 = done_seen;
    send_frame(16'h0000, 1'b1);
    check_eq("inc_frame", bus.output_data, frame_of(16'h0000));
    check_eq("inc_done_once", FS'(done_seen - d0), FS'(1));

    // Three words while the frame is pending: all dropped.
    o0 = overrun_seen;
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h5500 + WS'(i), 1'b0, 1'b0);
    check_eq("overrun_count", FS'(overrun_seen - o0), FS'(3));
    check_eq("overrun_data_held", bus.output_data, frame_of(16'h0000));
    cycle(1'b0, '0, 1'b0, 1'b1);
    send_frame(16'h2000, 1'b0);
    check_eq("after_overrun_frame", bus.output_data, frame_of(16'h2000));

    // Ready and a word coincide in HOLD.
    o0 = overrun_seen;
    cycle(1'b1, 16'hAAAA, 1'b0, 1'b1);
    for (int i = 1; i < NW; i++) cycle(1'b1, WS'(i), (i == NW - 1), 1'b0);
    check_eq("coincide_no_overrun", FS'(overrun_seen - o0), '0);
    check_eq("coincide_word0", FS'(bus.output_data[WS-1:0]), FS'(16'hAAAA));
    cycle(1'b0, '0, 1'b0, 1'b1);

`ifdef DESERIALIZER_LAST_CHECK_EN
    // Early end-of-frame on the 10th word discards the partial frame.
    f0 = ferr_seen;
    v0 = valid_seen;
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'h3000 + WS'(i), (i == 9), 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_eq("early_last_ferr", FS'(ferr_seen - f0), FS'(1));
    check_eq("early_last_no_valid", FS'(valid_seen - v0), '0);
    send_frame(16'h4000, 1'b0);
    check_eq("after_ferr_frame", bus.output_data, frame_of(16'h4000));
    cycle(1'b0, '0, 1'b0, 1'b1);
`else
    // input_last is ignored: random toggling must not disturb the frame.
    f0 = ferr_seen;
    for (int i = 0; i < NW; i++) cycle(1'b1, 16'h4000 + WS'(i), 1'($urandom), 1'b0);
    check_eq("ignore_last_frame", bus.output_data, frame_of(16'h4000));
    check_eq("ignore_last_no_ferr", FS'(ferr_seen - f0), '0);
    cycle(1'b0, '0, 1'b0, 1'b1);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit v, r, l;
      v = ($urandom % 4) != 0;
      r = ($urandom % 3) != 0;
      if (LAST_CHECK_EN)
        l = (partial_q.size() == NW - 1) ? (($urandom % 10) != 0) : (($urandom % 20) == 0);
      else
        l = 1'($urandom);
      cycle(v, WS'($urandom), l, r);
    end
    bus.input_valid = 1'b0;
    check_eq("random_frames_seen", FS'(done_seen > 5), FS'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
